// File: rtl/counter_10_if.sv
// rtl/counter_10_if.sv - enable/count/carry bundle of one BCD digit cell (optional load lines under COUNTER_10_LOAD_EN)
interface counter_10_if;
    logic       EN;
    logic [3:0] Q;
    logic       CO;
`ifdef COUNTER_10_LOAD_EN
    logic       nLD;
    logic [3:0] D;
`endif

`ifdef COUNTER_10_LOAD_EN
    modport master (output EN, output nLD, output D, input Q, input CO);
    modport slave  (input EN, input nLD, input D, output Q, output CO);
`else
    modport master (output EN, input Q, input CO);
    modport slave  (input EN, output Q, output CO);
`endif
endinterface

// File: rtl/counter_10.sv
// rtl/counter_10.sv - modulo-MODULUS BCD digit counter with carry; COUNTER_10_LOAD_EN adds synchronous load
module counter_10 #(
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input  logic          CP,
    input  logic          nCR,
    counter_10_if.slave   bus
);
    localparam logic [3:0] LAST  = 4'(MODULUS - 1);
    localparam logic [3:0] LIMIT = 4'(MODULUS);
    localparam logic [3:0] INIT  = 4'(RESET_VAL);

    generate
        if (MODULUS < 2 || MODULUS > 10 || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_param
            $error("counter_10: MODULUS must be 2..10 and RESET_VAL below MODULUS");
        end
    endgenerate

    logic [3:0] q_r;

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            q_r <= INIT;
`ifdef COUNTER_10_LOAD_EN
        end else if (!bus.nLD) begin
            // Out-of-range load values collapse to 0 so the digit never enters an illegal state.
            q_r <= (bus.D < LIMIT) ? bus.D : 4'd0;
`endif
        end else if (q_r > LAST) begin
            q_r <= 4'd0;
        end else if (bus.EN) begin
            q_r <= (q_r == LAST) ? 4'd0 : q_r + 4'd1;
        end
    end

    assign bus.Q  = q_r;
    // Carry is combinational so a chain of digits ripples within one cycle.
    assign bus.CO = bus.EN & (q_r == LAST);
endmodule

// File: tb/tb_counter_10.sv
// tb/tb_counter_10.sv - directed self-checking bench for counter_10 (load tests under COUNTER_10_LOAD_EN)
`timescale 1ns/1ps
module tb_counter_10;
    logic CP;
    logic nCR;
    int   errors = 0;
    int   checks = 0;

    counter_10_if bus();

    counter_10 #(.MODULUS(10), .RESET_VAL(0)) dut (
        .CP  (CP),
        .nCR (nCR),
        .bus (bus)
    );

    initial CP = 1'b0;
    always #10 CP = ~CP;

    task automatic step();
        @(posedge CP);
        @(negedge CP);
    endtask

    task automatic test_reset();
        nCR    = 1'b0;
        bus.EN = 1'b1;
`ifdef COUNTER_10_LOAD_EN
        bus.nLD = 1'b1;
        bus.D   = 4'd0;
`endif
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.Q !== 4'd0 || bus.CO !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: Q=%0d CO=%b, required Q=0 CO=0", i, bus.Q, bus.CO);
            end
            step();
        end
        nCR = 1'b1;
    endtask

    task automatic test_count();
        int exp_q;
        bus.EN = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_q = i % 10;
            checks++;
            if (bus.Q !== 4'(exp_q) || bus.CO !== (exp_q == 9)) begin
                errors++;
                $display("FAIL count[%0d]: Q=%0d CO=%b, required Q=%0d CO=%b",
                         i, bus.Q, bus.CO, exp_q, (exp_q == 9));
            end
        end
    endtask

    task automatic test_carry_gating();
        bus.EN = 1'b1;
        for (int i = 0; i < 9; i++) step();
        checks++;
        if (bus.Q !== 4'd9 || bus.CO !== 1'b1) begin
            errors++;
            $display("FAIL carry_en1: Q=%0d CO=%b, required Q=9 CO=1", bus.Q, bus.CO);
        end
        bus.EN = 1'b0;
        #1;
        checks++;
        if (bus.CO !== 1'b0) begin
            errors++;
            $display("FAIL carry_en0: CO=%b, required CO=0", bus.CO);
        end
        step();
        checks++;
        if (bus.Q !== 4'd9) begin
            errors++;
            $display("FAIL carry_hold9: Q=%0d, required Q=9", bus.Q);
        end
        bus.EN = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd0 || bus.CO !== 1'b0) begin
            errors++;
            $display("FAIL carry_wrap: Q=%0d CO=%b, required Q=0 CO=0", bus.Q, bus.CO);
        end
    endtask

    task automatic test_hold();
        bus.EN = 1'b1;
        for (int i = 0; i < 5; i++) step();
        bus.EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.Q !== 4'd5 || bus.CO !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: Q=%0d CO=%b, required Q=5 CO=0", i, bus.Q, bus.CO);
            end
        end
        bus.EN = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd6) begin
            errors++;
            $display("FAIL hold_resume: Q=%0d, required Q=6", bus.Q);
        end
    endtask

    task automatic test_async_clear();
        bus.EN = 1'b1;
        step();
        checks++;
        if (bus.Q !== 4'd7) begin
            errors++;
            $display("FAIL clear_pre: Q=%0d, required Q=7", bus.Q);
        end
        #3 nCR = 1'b0;
        #1;
        checks++;
        if (bus.Q !== 4'd0 || bus.CO !== 1'b0) begin
            errors++;
            $display("FAIL clear_async: Q=%0d CO=%b, required Q=0 CO=0", bus.Q, bus.CO);
        end
        step();
        checks++;
        if (bus.Q !== 4'd0) begin
            errors++;
            $display("FAIL clear_held: Q=%0d, required Q=0", bus.Q);
        end
        nCR = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (bus.Q !== 4'(i)) begin
                errors++;
                $display("FAIL clear_resume[%0d]: Q=%0d, required Q=%0d", i, bus.Q, i);
            end
        end
    endtask

    task automatic test_illegal();
        bus.EN = 1'b0;
        force dut.q_r = 4'd12;
        #1;
        checks++;
        if (bus.Q !== 4'd12 || bus.CO !== 1'b0) begin
            errors++;
            $display("FAIL illegal_en0: Q=%0d CO=%b, required Q=12 CO=0", bus.Q, bus.CO);
        end
        bus.EN = 1'b1;
        #1;
        checks++;
        if (bus.CO !== 1'b0) begin
            errors++;
            $display("FAIL illegal_en1: CO=%b, required CO=0", bus.CO);
        end
        bus.EN = 1'b0;
        release dut.q_r;
        step();
        checks++;
        if (bus.Q !== 4'd0 || bus.CO !== 1'b0) begin
            errors++;
            $display("FAIL illegal_recover: Q=%0d CO=%b, required Q=0 CO=0", bus.Q, bus.CO);
        end
    endtask

`ifdef COUNTER_10_LOAD_EN
    task automatic test_load();
        bus.EN  = 1'b1;
        bus.nLD = 1'b0;
        bus.D   = 4'd8;
        step();
        bus.nLD = 1'b1;
        checks++;
        if (bus.Q !== 4'd8) begin
            errors++;
            $display("FAIL load_8: Q=%0d, required Q=8", bus.Q);
        end
        step();
        checks++;
        if (bus.Q !== 4'd9 || bus.CO !== 1'b1) begin
            errors++;
            $display("FAIL load_next9: Q=%0d CO=%b, required Q=9 CO=1", bus.Q, bus.CO);
        end
        step();
        checks++;
        if (bus.Q !== 4'd0) begin
            errors++;
            $display("FAIL load_wrap: Q=%0d, required Q=0", bus.Q);
        end
        step();
        bus.nLD = 1'b0;
        bus.D   = 4'd13;
        step();
        checks++;
        if (bus.Q !== 4'd0) begin
            errors++;
            $display("FAIL load_13: Q=%0d, required Q=0", bus.Q);
        end
        bus.EN = 1'b0;
        bus.D  = 4'd3;
        step();
        bus.nLD = 1'b1;
        checks++;
        if (bus.Q !== 4'd3) begin
            errors++;
            $display("FAIL load_en0: Q=%0d, required Q=3", bus.Q);
        end
    endtask
`endif

    initial begin
        nCR    = 1'b0;
        bus.EN = 1'b0;
        test_reset();
        test_count();
        test_carry_gating();
        test_hold();
        test_async_clear();
        test_illegal();
`ifdef COUNTER_10_LOAD_EN
        test_load();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
